// File: rtl/target_detection_sys.sv
// rtl/target_detection_sys.sv - hyperspectral ACE numerator/denominator core
module target_detection_sys #(
    parameter int PIXEL_DATA_WIDTH = 16,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int NUM_BANDS        = 16,
    parameter int OUT_DATA_WIDTH   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_wr_en,
    input  logic [3:0]                  cfg_addr,
    input  logic [31:0]                 cfg_wdata,
    input  logic [PIXEL_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    input  logic                        S_AXIS_tlast,
    output logic                        S_AXIS_tready,
    output logic [OUT_DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    output logic                        M_AXIS_tlast,
    input  logic                        M_AXIS_tready,
    output logic                        cfg_loaded
);

    // Band/index counters rely on NUM_BANDS being a power of two so they wrap naturally.
    localparam int BW = $clog2(NUM_BANDS);
    localparam int MW = 2 * BW;
    localparam int XW = PIXEL_DATA_WIDTH + 1;   // sample zero-extended to a signed value
    localparam int PW = BRAM_DATA_WIDTH + XW;   // coefficient x sample product
    localparam int AW = 56;                     // accumulator width
    localparam logic [BW-1:0] LAST_BAND = BW'(NUM_BANDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_MVM   = 3'd2;
    localparam logic [2:0] S_SCALE = 3'd3;
    localparam logic [2:0] S_OUT0  = 3'd4;
    localparam logic [2:0] S_OUT1  = 3'd5;

    logic [2:0] state;

    logic [BRAM_DATA_WIDTH-1:0]  rinv_mem [NUM_BANDS*NUM_BANDS];
    logic [BRAM_DATA_WIDTH-1:0]  sr_mem   [NUM_BANDS];
    logic [BRAM_DATA_WIDTH-1:0]  srs;
    logic [PIXEL_DATA_WIDTH-1:0] x_mem    [NUM_BANDS];

    logic [MW-1:0] ptr_m;
    logic [BW-1:0] ptr_s;
    logic          debug;
    logic          frame_last;
    logic [BW-1:0] band;
    logic [BW-1:0] idx_i;
    logic [BW-1:0] idx_j;

    logic signed [AW-1:0] acc_a;
    logic signed [AW-1:0] acc_y;
    logic signed [AW-1:0] acc_q;
    logic signed [31:0]   d_reg;

    // Clamp a wide signed value into the 32-bit signed range.
    function automatic logic signed [31:0] sat32(input logic signed [AW-1:0] v);
        if (!v[AW-1] && (|v[AW-2:31])) return 32'sh7FFF_FFFF;
        if (v[AW-1] && !(&v[AW-2:31]))  return 32'sh8000_0000;
        return v[31:0];
    endfunction

    // Configuration is only accepted when no pixel computation is in flight.
    logic cfg_ok;
    assign cfg_ok = cfg_wr_en && !reset && (state == S_IDLE || state == S_RX);

    // Numerator term: sR[band] * x for the sample being accepted.
    logic signed [PW-1:0] op_sr, op_xin, prod_a;
    logic signed [AW-1:0] a_next;
    assign op_sr  = {{XW{sr_mem[band][BRAM_DATA_WIDTH-1]}}, sr_mem[band]};
    assign op_xin = {{(BRAM_DATA_WIDTH+1){1'b0}}, S_AXIS_tdata};
    assign prod_a = op_sr * op_xin;
    assign a_next = ((band == '0) ? '0 : acc_a) + {{(AW-PW){prod_a[PW-1]}}, prod_a};

    // Matrix-vector MAC: y_j += Rinv[j][i]*x_i, folding y_j into q on the last i.
    logic signed [PW-1:0] op_rinv, op_xi, prod_y;
    logic signed [AW-1:0] y_next;
    logic signed [31:0]   y_sat;
    logic signed [PW-1:0] op_ysat, op_xj, prod_q;
    logic signed [AW-1:0] q_next;
    assign op_rinv = {{XW{rinv_mem[{idx_j, idx_i}][BRAM_DATA_WIDTH-1]}}, rinv_mem[{idx_j, idx_i}]};
    assign op_xi   = {{(BRAM_DATA_WIDTH+1){1'b0}}, x_mem[idx_i]};
    assign prod_y  = op_rinv * op_xi;
    assign y_next  = ((idx_i == '0) ? '0 : acc_y) + {{(AW-PW){prod_y[PW-1]}}, prod_y};
    assign y_sat   = sat32(y_next >>> 16);
    assign op_ysat = {{XW{y_sat[31]}}, y_sat};
    assign op_xj   = {{(BRAM_DATA_WIDTH+1){1'b0}}, x_mem[idx_j]};
    assign prod_q  = op_ysat * op_xj;
    assign q_next  = acc_q + {{(AW-PW){prod_q[PW-1]}}, prod_q};

    // Denominator: q already carries integer scale after the per-row shift, so it is
    // clamped directly and the Q32 product with sRs keeps its upper word.
    logic signed [31:0] q_sat;
    logic signed [63:0] op_srs, op_qsat, prod_d;
    assign q_sat   = sat32(acc_q);
    assign op_srs  = {{32{srs[BRAM_DATA_WIDTH-1]}}, srs};
    assign op_qsat = {{32{q_sat[31]}}, q_sat};
    assign prod_d  = op_srs * op_qsat;

    logic signed [31:0] a_sat;
    assign a_sat = sat32(acc_a >>> 16);

    // Coefficient storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            case (cfg_addr)
                4'h0:    rinv_mem[ptr_m] <= cfg_wdata;
                4'h4:    sr_mem[ptr_s]   <= cfg_wdata;
                4'h8:    srs             <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // Write pointers, loaded flag and control register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_m      <= '0;
            ptr_s      <= '0;
            cfg_loaded <= 1'b0;
            debug      <= 1'b0;
        end else if (cfg_ok) begin
            case (cfg_addr)
                4'h0: ptr_m <= ptr_m + 1'b1;
                4'h4: ptr_s <= ptr_s + 1'b1;
                4'h8: cfg_loaded <= 1'b1;
                4'hC: begin
                    debug      <= cfg_wdata[0];
                    ptr_m      <= '0;
                    ptr_s      <= '0;
                    cfg_loaded <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Pixel pipeline: receive, matrix-vector multiply, scale, emit result beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            band       <= '0;
            idx_i      <= '0;
            idx_j      <= '0;
            frame_last <= 1'b0;
            acc_a      <= '0;
            acc_y      <= '0;
            acc_q      <= '0;
            d_reg      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_loaded) state <= S_RX;
                end
                S_RX: begin
                    if (S_AXIS_tvalid) begin
                        x_mem[band] <= S_AXIS_tdata;
                        acc_a       <= a_next;
                        if (S_AXIS_tlast) frame_last <= 1'b1;
                        if (band == LAST_BAND) begin
                            band  <= '0;
                            idx_i <= '0;
                            idx_j <= '0;
                            acc_q <= '0;
                            state <= S_MVM;
                        end else begin
                            band <= band + 1'b1;
                        end
                    end
                end
                S_MVM: begin
                    acc_y <= y_next;
                    idx_i <= idx_i + 1'b1;
                    if (idx_i == LAST_BAND) begin
                        acc_q <= q_next;
                        idx_j <= idx_j + 1'b1;
                        if (idx_j == LAST_BAND) state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    d_reg <= 32'(prod_d >>> 32);
                    state <= S_OUT0;
                end
                S_OUT0: begin
                    if (M_AXIS_tready) begin
                        if (debug) begin
                            frame_last <= 1'b0;
                            state      <= S_RX;
                        end else begin
                            state <= S_OUT1;
                        end
                    end
                end
                S_OUT1: begin
                    if (M_AXIS_tready) begin
                        frame_last <= 1'b0;
                        state      <= S_RX;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are pure functions of held state, so they stay stable under backpressure.
    assign S_AXIS_tready = (state == S_RX);
    assign M_AXIS_tvalid = (state == S_OUT0) || (state == S_OUT1);
    assign M_AXIS_tdata  = (state == S_OUT1) ? OUT_DATA_WIDTH'(d_reg) : OUT_DATA_WIDTH'(a_sat);
    assign M_AXIS_tlast  = frame_last && ((state == S_OUT1) || ((state == S_OUT0) && debug));

endmodule

// File: tb/tb_target_detection_sys.sv
// tb/tb_target_detection_sys.sv - scoreboard bench for target_detection_sys
module tb_target_detection_sys;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [15:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic        S_AXIS_tlast;
    logic        S_AXIS_tready;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tlast;
    logic        M_AXIS_tready;
    logic        cfg_loaded;

    target_detection_sys dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .S_AXIS_tready (S_AXIS_tready),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .M_AXIS_tready (M_AXIS_tready),
        .cfg_loaded    (cfg_loaded)
    );

    always #5 clk = ~clk;

    typedef logic [15:0] pix_t [16];
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    beat_idx     = 0;
    int    rinv_m [256];
    int    sr_m   [16];
    int    srs_m;
    bit    dbg_m;
    beat_t exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sat32m(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
        cfg_wr_en = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic load_cfg(input bit dbg);
        cfg_write(4'hC, {31'd0, dbg});
        dbg_m = dbg;
        for (int k = 0; k < 256; k++) cfg_write(4'h0, rinv_m[k]);
        for (int k = 0; k < 16; k++)  cfg_write(4'h4, sr_m[k]);
        cfg_write(4'h8, srs_m);
    endtask

    task automatic send_pixel(input pix_t px, input bit last);
        for (int b = 0; b < 16; b++) begin
            int n = 0;
            S_AXIS_tdata  = px[b];
            S_AXIS_tvalid = 1'b1;
            S_AXIS_tlast  = last && (b == 15);
            while (!S_AXIS_tready && n < 3000) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 3000) check("s_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
    endtask

    task automatic push_beat(input logic [31:0] data, input logic last);
        beat_t e;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Reference model of the ACE terms for the currently loaded configuration.
    task automatic push_model(input pix_t px, input bit last);
        longint a = 0;
        longint q = 0;
        longint y;
        longint d;
        for (int b = 0; b < 16; b++) a += longint'(sr_m[b]) * longint'(px[b]);
        for (int j = 0; j < 16; j++) begin
            y = 0;
            for (int i = 0; i < 16; i++) y += longint'(rinv_m[j*16+i]) * longint'(px[i]);
            q += sat32m(y >>> 16) * longint'(px[j]);
        end
        d = (longint'(srs_m) * sat32m(q)) >>> 32;
        if (dbg_m) begin
            push_beat(32'(sat32m(a >>> 16)), last);
        end else begin
            push_beat(32'(sat32m(a >>> 16)), 1'b0);
            push_beat(32'(d), last);
        end
    endtask

    task automatic rand_pix(output pix_t p);
        for (int b = 0; b < 16; b++) p[b] = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output monitor: every handshake pops one expected beat.
    initial begin
        forever begin
            @(negedge clk);
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d_data", beat_idx), 64'(M_AXIS_tdata), 64'(e.data));
                    check($sformatf("beat%0d_last", beat_idx), 64'(M_AXIS_tlast), 64'(e.last));
                end
                beat_idx++;
            end
        end
    end

    initial begin
        pix_t px, px2;
        int   cyc;
        reset = 1'b1;
        cfg_wr_en = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        S_AXIS_tdata = '0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast = 1'b0;
        M_AXIS_tready = 1'b1;
        dbg_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cfg_loaded", 64'(cfg_loaded), 64'd0);
        check("reset_s_tready", 64'(S_AXIS_tready), 64'd0);
        check("reset_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        check("reset_m_tlast", 64'(M_AXIS_tlast), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_s_tready", 64'(S_AXIS_tready), 64'd0);

        // Identity Rinv, unit sR/sRs, all-ones pixel.
        for (int k = 0; k < 256; k++) rinv_m[k] = (k / 16 == k % 16) ? 32'h0001_0000 : 0;
        for (int k = 0; k < 16; k++) sr_m[k] = 32'h0001_0000;
        srs_m = 32'h0001_0000;
        load_cfg(1'b0);
        check("cfg_loaded_set", 64'(cfg_loaded), 64'd1);
        for (int b = 0; b < 16; b++) px[b] = 16'd1;
        send_pixel(px, 1'b0);
        push_beat(32'd16, 1'b0);
        push_beat(32'd0, 1'b0);
        // Cycle 0 is the last-band acceptance; OUT0 appears in cycle 258.
        cyc = 1;
        while (!M_AXIS_tvalid && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'd258);
        drain();

        // Ramp pixel, then a large sRs.
        for (int b = 0; b < 16; b++) px[b] = 16'(b);
        send_pixel(px, 1'b0);
        push_beat(32'd120, 1'b0);
        push_beat(32'd0, 1'b0);
        drain();
        cfg_write(4'h8, 32'h7FFF_FFFF);
        srs_m = 32'h7FFF_FFFF;
        send_pixel(px, 1'b0);
        push_beat(32'd120, 1'b0);
        push_beat(32'd619, 1'b0);
        drain();

        // Ctrl write clears the loaded flag; then saturate both terms.
        cfg_write(4'hC, 32'd0);
        check("ctrl_clears_loaded", 64'(cfg_loaded), 64'd0);
        for (int k = 0; k < 256; k++) rinv_m[k] = 32'h7FFF_FFFF;
        for (int k = 0; k < 16; k++) sr_m[k] = 32'h8000_0000;
        srs_m = 32'h4000_0000;
        load_cfg(1'b0);
        for (int b = 0; b < 16; b++) px[b] = 16'hFFFF;
        send_pixel(px, 1'b0);
        push_beat(32'h8000_0000, 1'b0);
        push_beat(32'h1FFF_FFFF, 1'b0);
        drain();

        // Random signed configuration for the remaining tests.
        for (int k = 0; k < 256; k++) rinv_m[k] = int'($urandom);
        for (int k = 0; k < 16; k++) sr_m[k] = int'($urandom);
        srs_m = int'($urandom);
        load_cfg(1'b0);

        // Backpressure during OUT0 with the next pixel already presented.
        M_AXIS_tready = 1'b0;
        rand_pix(px);
        rand_pix(px2);
        send_pixel(px, 1'b0);
        push_model(px, 1'b0);
        fork
            begin
                send_pixel(px2, 1'b0);
                push_model(px2, 1'b0);
            end
            begin
                int n = 0;
                int bad = 0;
                int rdy = 0;
                logic [31:0] hold;
                while (!M_AXIS_tvalid && n < 1000) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("stall_tvalid_seen", 64'(M_AXIS_tvalid), 64'd1);
                hold = M_AXIS_tdata;
                repeat (50) begin
                    @(negedge clk);
                    if (M_AXIS_tdata !== hold || M_AXIS_tvalid !== 1'b1) bad++;
                    if (S_AXIS_tready) rdy++;
                end
                check("stall_hold_stable", 64'(bad), 64'd0);
                check("stall_s_tready_low", 64'(rdy), 64'd0);
                @(posedge clk); #1;
                M_AXIS_tready = 1'b1;
            end
        join
        drain();

        // Two pixels, frame end on the second.
        rand_pix(px);
        send_pixel(px, 1'b0);
        push_model(px, 1'b0);
        rand_pix(px);
        send_pixel(px, 1'b1);
        push_model(px, 1'b1);
        drain();

        // Debug mode: one beat per pixel carrying the frame end.
        load_cfg(1'b1);
        rand_pix(px);
        send_pixel(px, 1'b1);
        push_model(px, 1'b1);
        rand_pix(px);
        send_pixel(px, 1'b0);
        push_model(px, 1'b0);
        drain();

        // Reset during MVM discards the pixel; coefficients survive.
        rand_pix(px);
        send_pixel(px, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mvm_reset_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        check("mvm_reset_s_tready", 64'(S_AXIS_tready), 64'd0);
        check("mvm_reset_loaded", 64'(cfg_loaded), 64'd0);
        dbg_m = 1'b0;
        cfg_write(4'h8, srs_m);
        check("reload_loaded", 64'(cfg_loaded), 64'd1);
        rand_pix(px);
        send_pixel(px, 1'b1);
        push_model(px, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
